// File: rtl/mpt_pkg.sv
// Shared MPT walker types.
// Port IDs used by the PLB cache port arbiter.
package mpt_pkg;

    typedef logic plb_arb_id_t;

    localparam int PLB_ARB_NUM_PORTS = 2;

endpackage

// File: rtl/plb_port_arbiter_if.sv
// PLB cache MEM port bundle.
// master drives the request side, slave returns grant and response.
interface plb_port_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  mem_req;
    logic                  mem_gnt;
    logic                  mem_valid;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [BE_WIDTH-1:0]   mem_be;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_error;

    modport master (
        output mem_req, mem_addr, mem_wdata, mem_we, mem_be,
        input  mem_gnt, mem_valid, mem_rdata, mem_error
    );

    modport slave (
        input  mem_req, mem_addr, mem_wdata, mem_we, mem_be,
        output mem_gnt, mem_valid, mem_rdata, mem_error
    );

endinterface

// File: rtl/plb_arb_id_fifo.sv
// Outstanding-ID FIFO for the PLB port arbiter.
// Power-of-two depth; pointers wrap naturally.
module plb_arb_id_fifo
    import mpt_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  plb_arb_id_t   data_i,
    output plb_arb_id_t   data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    plb_arb_id_t   mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wr_d = wr_q + PW'(1);
        if (do_pop)  rd_d = rd_q + PW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/plb_port_arbiter.sv
// Two-port round-robin arbiter in front of the PLB cache MEM port.
// Lookup path on port 0, refill path on port 1; responses routed by ID FIFO.
module plb_port_arbiter
    import mpt_pkg::*;
#(
    parameter  int DATA_WIDTH      = 64,
    parameter  int ADDR_WIDTH      = 64,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CW              = $clog2(MAX_OUTSTANDING) + 1,
    localparam int BW              = DATA_WIDTH / 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    plb_port_arbiter_if.slave          s0_mem,
    plb_port_arbiter_if.slave          s1_mem,
    plb_port_arbiter_if.master         plb_mem,
    output logic                       unexpected_rsp_o,
    output logic [CW-1:0]              outstanding_o
);

    logic [PLB_ARB_NUM_PORTS-1:0] req_vec;
    plb_arb_id_t                  win;
    plb_arb_id_t                  head;
    plb_arb_id_t                  rr_ptr_q, rr_ptr_d;
    plb_arb_id_t                  lock_id_q, lock_id_d;
    logic                         locked_q, locked_d;
    logic                         unexp_q, unexp_d;
    logic                         issue, hs, pop;
    logic                         full, empty;
    logic [ADDR_WIDTH-1:0]        addr_mux;
    logic [DATA_WIDTH-1:0]        wdata_mux;
    logic [DATA_WIDTH-1:0]        rdata;
    logic [BW-1:0]                be_mux;

    assign req_vec = {s1_mem.mem_req, s0_mem.mem_req};

    // A locked winner overrides rr_ptr so its request stays stable.
    always_comb begin
        if (locked_q)        win = lock_id_q;
        else if (&req_vec)   win = rr_ptr_q;
        else if (req_vec[1]) win = 1'b1;
        else                 win = 1'b0;
    end

    assign issue = (|req_vec) & ~full;
    assign hs    = issue & plb_mem.mem_gnt;
    assign pop   = plb_mem.mem_valid & ~empty;

    assign addr_mux  = win ? s1_mem.mem_addr  : s0_mem.mem_addr;
    assign wdata_mux = win ? s1_mem.mem_wdata : s0_mem.mem_wdata;
    assign be_mux    = win ? s1_mem.mem_be    : s0_mem.mem_be;

    assign plb_mem.mem_req   = issue;
    assign plb_mem.mem_addr  = addr_mux;
    assign plb_mem.mem_wdata = wdata_mux;
    assign plb_mem.mem_be    = be_mux;
    assign plb_mem.mem_we    = win ? s1_mem.mem_we : s0_mem.mem_we;

    assign s0_mem.mem_gnt = hs & ~win;
    assign s1_mem.mem_gnt = hs & win;

    assign rdata = plb_mem.mem_rdata;

    assign s0_mem.mem_valid = pop & ~head;
    assign s1_mem.mem_valid = pop & head;
    assign s0_mem.mem_rdata = rdata;
    assign s1_mem.mem_rdata = rdata;
    assign s0_mem.mem_error = plb_mem.mem_error & pop & ~head;
    assign s1_mem.mem_error = plb_mem.mem_error & pop & head;

    assign unexpected_rsp_o = unexp_q;

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        locked_d  = locked_q;
        lock_id_d = lock_id_q;
        unexp_d   = unexp_q | (plb_mem.mem_valid & empty);
        if (hs) begin
            rr_ptr_d = ~win;
            locked_d = 1'b0;
        end else if (issue) begin
            locked_d  = 1'b1;
            lock_id_d = win;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q  <= 1'b0;
            lock_id_q <= 1'b0;
            locked_q  <= 1'b0;
            unexp_q   <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
            locked_q  <= locked_d;
            unexp_q   <= unexp_d;
        end
    end

    plb_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .pop_i   (pop),
        .data_i  (win),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding_o)
    );

endmodule

// File: tb/tb_plb_port_arbiter.sv
// Bench for plb_port_arbiter: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_plb_port_arbiter;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int BW = DW / 8;
    localparam int MO = 4;
    localparam int CW = $clog2(MO) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    plb_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s0_if ();
    plb_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s1_if ();
    plb_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) plb_if ();

    logic          unexp;
    logic [CW-1:0] outst;

    plb_port_arbiter #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .s0_mem           (s0_if),
        .s1_mem           (s1_if),
        .plb_mem          (plb_if),
        .unexpected_rsp_o (unexp),
        .outstanding_o    (outst)
    );

    int total = 0;
    int bad   = 0;

    // slave-side stimulus state
    logic          req   [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic          we    [2];
    logic [BW-1:0] be    [2];

    // reference model: in-flight port IDs, preferred port, waiting winner
    int q[$];
    int pref;
    int held;
    bit sticky;

    // observations from the last step
    int            last_win;
    logic          o_req, o_g0, o_g1, o_v0, o_v1, o_unexp;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata, o_rdata;
    logic [BW-1:0] o_be;
    logic [CW-1:0] o_outst;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic g, input logic v,
                         input logic [DW-1:0] rd, input logic er);
        s0_if.mem_req   = req[0];
        s0_if.mem_addr  = addr[0];
        s0_if.mem_wdata = wdata[0];
        s0_if.mem_we    = we[0];
        s0_if.mem_be    = be[0];
        s1_if.mem_req   = req[1];
        s1_if.mem_addr  = addr[1];
        s1_if.mem_wdata = wdata[1];
        s1_if.mem_we    = we[1];
        s1_if.mem_be    = be[1];
        plb_if.mem_gnt   = g;
        plb_if.mem_valid = v;
        plb_if.mem_rdata = rd;
        plb_if.mem_error = er;
    endtask

    task automatic new_req(input int p);
        req[p]   = 1'b1;
        addr[p]  = {$urandom, $urandom};
        wdata[p] = {$urandom, $urandom};
        we[p]    = 1'($urandom_range(0, 1));
        be[p]    = BW'($urandom);
    endtask

    // One cycle: drive at negedge, check after settle, advance model at posedge.
    task automatic step(input logic g, input logic v,
                        input logic [DW-1:0] rd, input logic er);
        int   w;
        int   head;
        logic full, ereq, hs, pop;
        drive(g, v, rd, er);
        #1;
        full = (q.size() == MO);
        if (held >= 0)              w = held;
        else if (req[0] && req[1]) w = pref;
        else                        w = req[1] ? 1 : 0;
        ereq = (req[0] | req[1]) & !full;
        hs   = ereq & g;
        pop  = v && (q.size() > 0);
        head = pop ? q[0] : 0;
        chk("plb_req", 64'(plb_if.mem_req), 64'(ereq));
        if (ereq) begin
            chk("plb_addr", 64'(plb_if.mem_addr), 64'(addr[w]));
            chk("plb_wdata", 64'(plb_if.mem_wdata), 64'(wdata[w]));
            chk("plb_we", 64'(plb_if.mem_we), 64'(we[w]));
            chk("plb_be", 64'(plb_if.mem_be), 64'(be[w]));
        end
        chk("s0_gnt", 64'(s0_if.mem_gnt), 64'(hs && w == 0));
        chk("s1_gnt", 64'(s1_if.mem_gnt), 64'(hs && w == 1));
        chk("s0_valid", 64'(s0_if.mem_valid), 64'(pop && head == 0));
        chk("s1_valid", 64'(s1_if.mem_valid), 64'(pop && head == 1));
        if (pop) begin
            if (head == 0) begin
                chk("s0_rdata", 64'(s0_if.mem_rdata), 64'(rd));
                chk("s0_error", 64'(s0_if.mem_error), 64'(er));
            end else begin
                chk("s1_rdata", 64'(s1_if.mem_rdata), 64'(rd));
                chk("s1_error", 64'(s1_if.mem_error), 64'(er));
            end
        end
        chk("unexpected", 64'(unexp), 64'(sticky));
        chk("outstanding", 64'(outst), 64'(q.size()));
        o_req   = plb_if.mem_req;
        o_g0    = s0_if.mem_gnt;
        o_g1    = s1_if.mem_gnt;
        o_v0    = s0_if.mem_valid;
        o_v1    = s1_if.mem_valid;
        o_rdata = s0_if.mem_valid ? s0_if.mem_rdata : s1_if.mem_rdata;
        o_addr  = plb_if.mem_addr;
        o_wdata = plb_if.mem_wdata;
        o_be    = plb_if.mem_be;
        o_unexp = unexp;
        o_outst = outst;
        last_win = hs ? w : -1;
        @(posedge clk);
        if (v && q.size() == 0) sticky = 1'b1;
        if (pop) void'(q.pop_front());
        if (hs) begin
            q.push_back(w);
            pref   = 1 - w;
            held   = -1;
            req[w] = 1'b0;
        end else if (ereq) begin
            held = w;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        pref   = 0;
        held   = -1;
        sticky = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
            we[p] = 1'b0; be[p] = '0;
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("rst_outstanding", 64'(outst), 64'd0);
        chk("rst_unexpected", 64'(unexp), 64'd0);
        chk("rst_plb_req", 64'(plb_if.mem_req), 64'd0);
        chk("rst_gnt", 64'({s0_if.mem_gnt, s1_if.mem_gnt}), 64'd0);
        chk("rst_valid", 64'({s0_if.mem_valid, s1_if.mem_valid}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
            we[p] = 1'b0; be[p] = '0;
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        do_reset();

        // single port-0 read
        req[0] = 1'b1; addr[0] = 64'h1000; we[0] = 1'b0; be[0] = '1;
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t1_gnt0", 64'(o_g0), 64'd1);
        chk("t1_gnt1", 64'(o_g1), 64'd0);
        chk("t1_addr", 64'(o_addr), 64'h1000);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t1_outst1", 64'(o_outst), 64'd1);
        step(1'b0, 1'b1, 64'hDEAD, 1'b0);
        chk("t1_valid0", 64'(o_v0), 64'd1);
        chk("t1_valid1", 64'(o_v1), 64'd0);
        chk("t1_rdata", 64'(o_rdata), 64'hDEAD);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t1_outst0", 64'(o_outst), 64'd0);

        // continuous contention alternates grants and responses
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 6) begin
                if (!req[0]) new_req(0);
                if (!req[1]) new_req(1);
            end
            step(1'b1, 1'(i > 0), 64'(i), 1'b0);
            if (i < 6) chk("t2_order", 64'(last_win), 64'(i % 2));
            if (i > 0) chk("t2_rsp", 64'({o_v1, o_v0}),
                           ((i - 1) % 2 == 0) ? 64'd1 : 64'd2);
        end

        // lock keeps port 1 write stable while gnt is withheld
        do_reset();
        req[1] = 1'b1; addr[1] = 64'h40; wdata[1] = 64'hFF;
        be[1] = 8'h01; we[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                req[0] = 1'b1; addr[0] = 64'h2000; wdata[0] = 64'h11;
                be[0] = 8'hF0; we[0] = 1'b0;
            end
            step(1'b0, 1'b0, '0, 1'b0);
            chk("t3_addr", 64'(o_addr), 64'h40);
            chk("t3_wdata", 64'(o_wdata), 64'hFF);
            chk("t3_be", 64'(o_be), 64'h01);
        end
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t3_win1", 64'(last_win), 64'd1);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t3_win0", 64'(last_win), 64'd0);
        chk("t3_addr0", 64'(o_addr), 64'h2000);

        // full FIFO blocks issue, then pointers wrap
        do_reset();
        for (int i = 0; i < 4; i++) begin
            new_req(0);
            step(1'b1, 1'b0, '0, 1'b0);
        end
        new_req(0); new_req(1);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t4_req_full", 64'(o_req), 64'd0);
        chk("t4_gnt_full", 64'({o_g1, o_g0}), 64'd0);
        chk("t4_outst", 64'(o_outst), 64'd4);
        step(1'b1, 1'b1, 64'h77, 1'b1);
        chk("t4_req_pop", 64'(o_req), 64'd0);
        chk("t4_pop_v0", 64'(o_v0), 64'd1);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t4_req_again", 64'(o_req), 64'd1);
        for (int i = 0; i < 16; i++) begin
            if (!req[0]) new_req(0);
            if (!req[1]) new_req(1);
            step(1'b1, 1'(i % 3 != 0), {$urandom, $urandom}, 1'b0);
        end

        // response with nothing outstanding
        do_reset();
        step(1'b0, 1'b1, 64'h55, 1'b0);
        chk("t5_no_valid", 64'({o_v1, o_v0}), 64'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t5_sticky", 64'(o_unexp), 64'd1);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t5_held", 64'(o_unexp), 64'd1);
        do_reset();

        // async reset with transactions in flight
        for (int i = 0; i < 3; i++) begin
            new_req(i % 2);
            step(1'b1, 1'b0, '0, 1'b0);
        end
        chk("t6_pre", 64'(outst), 64'd3);
        do_reset();
        new_req(0); new_req(1);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t6_first_win", 64'(last_win), 64'd0);

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 2; p++)
                if (!req[p] && $urandom_range(0, 2) != 0) new_req(p);
            step(1'($urandom_range(0, 3) != 0),
                 1'(q.size() > 0 && $urandom_range(0, 2) != 0),
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
